// File: rtl/dds_sweep_ctrl_if.sv
// Interface bundling the sweep controller's control inputs and DDS-facing
// outputs.
//   master : sequencer/host side. Drives start, abort, the sweep configuration
//            and repeat_en; observes phase_inc, phase_clr, busy, sweep_done
//            and cfg_err.
//   slave  : dds_sweep_ctrl side, with the opposite directions.
// Parameters: INC_W (tuning-word width), DWELL_W (dwell counter width).
interface dds_sweep_ctrl_if #(
  parameter int INC_W   = 16,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [INC_W-1:0]   f_start;
  logic [INC_W-1:0]   f_stop;
  logic [INC_W-1:0]   f_step;
  logic [DWELL_W-1:0] dwell;
  logic               repeat_en;
  logic [INC_W-1:0]   phase_inc;
  logic               phase_clr;
  logic               busy;
  logic               sweep_done;
  logic               cfg_err;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell, repeat_en,
    input  phase_inc, phase_clr, busy, sweep_done, cfg_err
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell, repeat_en,
    output phase_inc, phase_clr, busy, sweep_done, cfg_err
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS sine generator.
// It ramps the tuning word from f_start to f_stop in steps of f_step. Each
// word is held for dwell+1 cycles. A phase-accumulator clear is pulsed at the
// start of every pass. Single-shot and repeating sweeps are supported, as are
// abort and rejection of a bad configuration.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dds_sweep_ctrl_if.slave. Inputs are start, abort, f_start,
//              f_stop, f_step, dwell and repeat_en. Outputs are phase_inc,
//              phase_clr, busy, sweep_done and cfg_err.
// Build option: defining SWEEP_BIDIR_EN adds a DOWN state. The sweep then
// returns from f_stop to f_start before the pass ends.
module dds_sweep_ctrl #(
  parameter int INC_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dds_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE
    , UP
`ifdef SWEEP_BIDIR_EN
    , DOWN
`endif
  } state_t;

  state_t             state;
  logic [INC_W-1:0]   phase_inc;
  logic               phase_clr;
  logic               busy;
  logic               sweep_done;
  logic               cfg_err;
  logic [DWELL_W-1:0] cnt;

  // Latched sweep configuration. Only these copies are used once a sweep runs.
  logic [INC_W-1:0]   start_l;
  logic [INC_W-1:0]   stop_l;
  logic [INC_W-1:0]   step_l;
  logic [DWELL_W-1:0] dwell_l;
  logic               rep_l;

  logic cfg_ok;
  logic accept;
  logic pass_end;

  // Compute the sum one bit wider so that a carry out also clamps to the limit.
  function automatic logic [INC_W-1:0] sat_add(
    input logic [INC_W-1:0] a,
    input logic [INC_W-1:0] step,
    input logic [INC_W-1:0] lim
  );
    logic [INC_W:0] sum;
    sum = {1'b0, a} + {1'b0, step};
    if (sum[INC_W] || (sum[INC_W-1:0] > lim)) return lim;
    return sum[INC_W-1:0];
  endfunction

`ifdef SWEEP_BIDIR_EN
  // a >= floor always holds here, so a - floor cannot borrow. Comparing that
  // distance with the step keeps the result at or above floor.
  function automatic logic [INC_W-1:0] sat_sub(
    input logic [INC_W-1:0] a,
    input logic [INC_W-1:0] step,
    input logic [INC_W-1:0] floor
  );
    if ((a - floor) <= step) return floor;
    return a - step;
  endfunction
`endif

  assign cfg_ok = (bus.f_start <= bus.f_stop) && (bus.f_step != '0);
  assign accept = (state == IDLE) && bus.start && !bus.abort && cfg_ok;

  // A pass ends when the final word of the pass has used up its dwell.
  always_comb begin
    pass_end = 1'b0;
    if (cnt == '0) begin
`ifdef SWEEP_BIDIR_EN
      // When start equals stop there is no down leg, so the pass ends at the
      // top.
      if ((state == UP) && (phase_inc == stop_l) && (start_l == stop_l))
        pass_end = 1'b1;
      if ((state == DOWN) && (phase_inc == start_l))
        pass_end = 1'b1;
`else
      if ((state == UP) && (phase_inc == stop_l))
        pass_end = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      start_l <= bus.f_start;
      stop_l  <= bus.f_stop;
      step_l  <= bus.f_step;
      dwell_l <= bus.dwell;
      rep_l   <= bus.repeat_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase_inc  <= '0;
      phase_clr  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      phase_clr  <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        phase_inc <= '0;
        cnt       <= '0;
      end else if (state == IDLE) begin
        if (bus.start) begin
          if (cfg_ok) begin
            state     <= UP;
            phase_inc <= bus.f_start;
            phase_clr <= 1'b1;
            busy      <= 1'b1;
            cnt       <= bus.dwell;
          end else begin
            cfg_err   <= 1'b1;
          end
        end
      end else if (pass_end) begin
        sweep_done <= 1'b1;
        if (rep_l) begin
          state     <= UP;
          phase_inc <= start_l;
          phase_clr <= 1'b1;
          cnt       <= dwell_l;
        end else begin
          state     <= IDLE;
          busy      <= 1'b0;
          phase_inc <= '0;
          cnt       <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= dwell_l;
        case (state)
          UP: begin
`ifdef SWEEP_BIDIR_EN
            if (phase_inc == stop_l) begin
              state     <= DOWN;
              phase_inc <= sat_sub(phase_inc, step_l, start_l);
            end else begin
              phase_inc <= sat_add(phase_inc, step_l, stop_l);
            end
`else
            phase_inc <= sat_add(phase_inc, step_l, stop_l);
`endif
          end
`ifdef SWEEP_BIDIR_EN
          DOWN: phase_inc <= sat_sub(phase_inc, step_l, start_l);
`endif
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.phase_inc  = phase_inc;
  assign bus.phase_clr  = phase_clr;
  assign bus.busy       = busy;
  assign bus.sweep_done = sweep_done;
  assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl. The expected tuning-word sequences
// are written out by hand from the sweep rules.
module tb_dds_sweep_ctrl;
  localparam int INC_W   = 16;
  localparam int DWELL_W = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  dds_sweep_ctrl_if #(.INC_W(INC_W), .DWELL_W(DWELL_W)) bus ();

  dds_sweep_ctrl #(.INC_W(INC_W), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Wait one clock edge, release start, then compare all outputs.
  task automatic cyc(input string tag, input int inc, input int clr,
                     input int bsy, input int done, input int err);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, ".inc"},  int'(bus.phase_inc),  inc);
    chk({tag, ".clr"},  int'(bus.phase_clr),  clr);
    chk({tag, ".busy"}, int'(bus.busy),       bsy);
    chk({tag, ".done"}, int'(bus.sweep_done), done);
    chk({tag, ".err"},  int'(bus.cfg_err),    err);
  endtask

  task automatic go(input int fs, input int fe, input int st, input int dw,
                    input logic rep);
    bus.f_start   = INC_W'(fs);
    bus.f_stop    = INC_W'(fe);
    bus.f_step    = INC_W'(st);
    bus.dwell     = DWELL_W'(dw);
    bus.repeat_en = rep;
    bus.start     = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0;
    bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.inc",  int'(bus.phase_inc), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.clr",  int'(bus.phase_clr), 0);
    rst = 1'b0;
    cyc("idle", 0, 0, 0, 0, 0);

`ifndef SWEEP_BIDIR_EN
    // 100..400 step 100, dwell 2: every word is held for 3 cycles.
    go(100, 400, 100, 2, 1'b0);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++)
        cyc("ramp1", 100 + 100 * w, (w == 0 && k == 0) ? 1 : 0, 1, 0, 0);
    cyc("ramp1.end", 0, 0, 0, 1, 0);
    cyc("ramp1.idle", 0, 0, 0, 0, 0);

    // The last step is clamped to stop.
    go(100, 350, 100, 0, 1'b0);
    cyc("clamp.0", 100, 1, 1, 0, 0);
    cyc("clamp.1", 200, 0, 1, 0, 0);
    cyc("clamp.2", 300, 0, 1, 0, 0);
    cyc("clamp.3", 350, 0, 1, 0, 0);
    cyc("clamp.end", 0, 0, 0, 1, 0);

    // A carry out of the top bit must clamp rather than wrap.
    go(65000, 65535, 400, 0, 1'b0);
    cyc("carry.0", 65000, 1, 1, 0, 0);
    cyc("carry.1", 65400, 0, 1, 0, 0);
    cyc("carry.2", 65535, 0, 1, 0, 0);
    cyc("carry.end", 0, 0, 0, 1, 0);

    // Repeating sweep 100->200 dwell 1. A second start mid-sweep is ignored.
    go(100, 200, 100, 1, 1'b1);
    cyc("rep.c1", 100, 1, 1, 0, 0);
    cyc("rep.c2", 100, 0, 1, 0, 0);
    go(7, 9000, 1, 5, 1'b0);
    cyc("rep.c3", 200, 0, 1, 0, 0);
    cyc("rep.c4", 200, 0, 1, 0, 0);
    cyc("rep.c5", 100, 1, 1, 1, 0);
    cyc("rep.c6", 100, 0, 1, 0, 0);
    cyc("rep.c7", 200, 0, 1, 0, 0);
    cyc("rep.c8", 200, 0, 1, 0, 0);
    cyc("rep.c9", 100, 1, 1, 1, 0);
    bus.abort = 1'b1;
    cyc("abort", 0, 0, 0, 0, 0);
    bus.abort = 1'b0;
    cyc("abort.idle", 0, 0, 0, 0, 0);
`else
    // Up then down, with a start during the sweep that must be ignored.
    go(100, 300, 100, 0, 1'b0);
    cyc("bidir.0", 100, 1, 1, 0, 0);
    go(5, 60000, 7, 3, 1'b1);
    cyc("bidir.1", 200, 0, 1, 0, 0);
    cyc("bidir.2", 300, 0, 1, 0, 0);
    cyc("bidir.3", 200, 0, 1, 0, 0);
    cyc("bidir.4", 100, 0, 1, 0, 0);
    cyc("bidir.end", 0, 0, 0, 1, 0);
    cyc("bidir.idle", 0, 0, 0, 0, 0);
`endif

    // Bad configurations are rejected.
    go(500, 100, 100, 0, 1'b0);
    cyc("err.order", 0, 0, 0, 0, 1);
    cyc("err.order2", 0, 0, 0, 0, 0);
    go(100, 400, 0, 0, 1'b0);
    cyc("err.step", 0, 0, 0, 0, 1);

    // A single-word sweep is valid.
    go(250, 250, 10, 1, 1'b0);
    cyc("one.0", 250, 1, 1, 0, 0);
    cyc("one.1", 250, 0, 1, 0, 0);
    cyc("one.end", 0, 0, 0, 1, 0);

    // abort beats start in IDLE.
    go(100, 200, 100, 0, 1'b0);
    bus.abort = 1'b1;
    cyc("abst", 0, 0, 0, 0, 0);
    bus.abort = 1'b0;
    cyc("abst.idle", 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a sweep.
    go(1000, 5000, 10, 3, 1'b1);
    cyc("prerst", 1000, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst.inc",  int'(bus.phase_inc), 0);
    chk("arst.busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("arst.idle", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
